// File: rtl/test_unit_pkg.sv
// test_unit_pkg: shared width constant and default-width sum type for test_unit.
package test_unit_pkg;
  localparam int DEFAULT_N = 10;
  typedef logic [DEFAULT_N:0] sum_t;
endpackage

// File: rtl/test_unit_if.sv
// test_unit_if: bundle of test_unit data signals with a modport for the block side.
interface test_unit_if #(parameter int N = test_unit_pkg::DEFAULT_N) (input logic clk);
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic [N-1:0] c;
  modport dut (input a, b, clk, output c);
endinterface

// File: rtl/test_unit_sat_add.sv
// test_unit_sat_add: combinational N-bit unsigned saturating adder.
module test_unit_sat_add
  import test_unit_pkg::*;
#(
  parameter int N = DEFAULT_N
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] s
);
  logic [N:0] sum;
  always_comb begin
    sum = {1'b0, a} + {1'b0, b};
    s = sum[N] ? '1 : sum[N-1:0];
  end
endmodule

// File: rtl/test_unit.sv
// test_unit: two-stage registered unsigned saturating adder, one result per cycle.
module test_unit
  import test_unit_pkg::*;
#(
  parameter int N = DEFAULT_N
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] c
);
  logic [N-1:0] a_q, b_q, s;
  test_unit_sat_add #(.N(N)) u_add (.a(a_q), .b(b_q), .s(s));
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q <= '0;
      b_q <= '0;
      c <= '0;
    end else begin
      a_q <= a;
      b_q <= b;
      c <= s;
    end
  end
endmodule

// File: tb/tb_test_unit.sv
// tb_test_unit: scoreboard bench for test_unit at N=10 (via interface) and N=4.
module tb_test_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [3:0] a4 = '0, b4 = '0, c4;
  int checks = 0;
  int errors = 0;
  int q10[$];
  int q4[$];
  always #10 clk = ~clk;
  test_unit_if #(.N(10)) ifc (.clk(clk));
  test_unit #(.N(10)) dut10 (.clk(ifc.clk), .rst(rst), .a(ifc.a), .b(ifc.b), .c(ifc.c));
  test_unit #(.N(4)) dut4 (.clk(clk), .rst(rst), .a(a4), .b(b4), .c(c4));
  function automatic int sat(input int x, input int y, input int n);
    int m;
    m = (1 << n) - 1;
    return ((x & m) + (y & m) > m) ? m : (x & m) + (y & m);
  endfunction
  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic step(input int x, input int y, input string tag);
    int e10, e4;
    logic [31:0] xv, yv;
    xv = x;
    yv = y;
    ifc.a = xv[9:0];
    ifc.b = yv[9:0];
    a4 = xv[3:0];
    b4 = yv[3:0];
    @(posedge clk);
    e10 = q10.pop_front();
    e4 = q4.pop_front();
    q10.push_back(sat(x, y, 10));
    q4.push_back(sat(x, y, 4));
    @(negedge clk);
    check({tag, "_c10"}, int'(ifc.c), e10);
    check({tag, "_c4"}, int'(c4), e4);
  endtask
  task automatic clear_model();
    q10.delete();
    q4.delete();
    q10.push_back(0);
    q4.push_back(0);
  endtask
  initial begin
    ifc.a = '0;
    ifc.b = '0;
    clear_model();
    #1;
    check("reset_c10", int'(ifc.c), 0);
    check("reset_c4", int'(c4), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    step(1, 1, "basic_k");
    step(0, 0, "basic_k1");
    step(0, 0, "basic_k2");
    step(1023, 1, "sat_max1");
    step(600, 600, "sat_600");
    step(0, 0, "sat_a");
    step(1023, 0, "max_zero");
    step(0, 0, "sat_b");
    step(0, 0, "zero");
    step(0, 0, "zero2");
    step(1, 2, "thr0");
    step(3, 4, "thr1");
    step(10, 20, "thr2");
    step(9, 9, "thr3");
    step(3, 4, "p4_a");
    step(0, 0, "p4_b");
    step(0, 0, "p4_c");
    repeat (4) step(5, 7, "pre_rst");
    #3 rst = 1'b1;
    #1;
    check("rst_async_c10", int'(ifc.c), 0);
    check("rst_async_c4", int'(c4), 0);
    clear_model();
    @(posedge clk);
    @(negedge clk);
    check("rst_hold_c10", int'(ifc.c), 0);
    check("rst_hold_c4", int'(c4), 0);
    rst = 1'b0;
    step(5, 7, "post_rst1");
    step(5, 7, "post_rst2");
    step(5, 7, "post_rst3");
    for (int i = 0; i < 1000; i++)
      step(int'($urandom_range(1023)), int'($urandom_range(1023)), "rand");
    step(0, 0, "flush1");
    step(0, 0, "flush2");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
